// File: rtl/tl_pkg.sv
// Shared transaction-layer types: per-class credit increment bundle for VC0.
package tl_pkg;
    localparam int unsigned HDR_W  = 8;
    localparam int unsigned DATA_W = 12;

    typedef struct packed {
        logic [HDR_W-1:0]  ph;
        logic [DATA_W-1:0] pd;
        logic [HDR_W-1:0]  nph;
        logic [DATA_W-1:0] npd;
        logic [HDR_W-1:0]  cplh;
        logic [DATA_W-1:0] cpld;
    } tl_credit_t;
endpackage

// File: rtl/tl_fc_dllp_rx.sv
// VC0 receive flow-control DLLP tracker: InitFC1/InitFC2 handshake and limit-to-increment conversion.
// Optional macro TL_FC_LIMIT_CHECK_EN rejects UpdateFC deltas above half the counter range.
module tl_fc_dllp_rx #(
    parameter int unsigned HDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned VC_ID      = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dl_up_i,
    input  logic                dllp_valid_i,
    input  logic [31:0]         dllp_i,
    output tl_pkg::tl_credit_t  fc_update_o,
    output logic                fc_valid_o,
    output logic [5:0]          fc_infinite_o,
    output logic                fc_init1_done_o,
    output logic                fc_init_done_o,
    output logic                fc_err_o
);
    localparam int unsigned PH_W = tl_pkg::HDR_W;
    localparam int unsigned PD_W = tl_pkg::DATA_W;

    typedef enum logic [1:0] {FC_INIT1, FC_INIT2, FC_ACTIVE} fc_state_t;

    fc_state_t               r_state, w_state_nxt;
    logic [HDR_WIDTH-1:0]    r_lim_h [3];
    logic [DATA_WIDTH-1:0]   r_lim_d [3];
    logic [HDR_WIDTH-1:0]    w_lim_h_nxt [3];
    logic [DATA_WIDTH-1:0]   w_lim_d_nxt [3];
    logic [HDR_WIDTH-1:0]    w_inc_h [3];
    logic [DATA_WIDTH-1:0]   w_inc_d [3];
    logic [2:0]              r_seen, w_seen_nxt;
    logic [2:0]              r_inf_h, r_inf_d, w_inf_h_nxt, w_inf_d_nxt;
    logic                    r_valid, w_valid_nxt;
    tl_pkg::tl_credit_t      r_upd, w_upd_nxt;
    logic                    r_err, w_err_nxt;

    // Type byte is {kind[1:0], class[1:0], 1'b0, vc[2:0]}; kind 01=InitFC1, 11=InitFC2, 10=UpdateFC.
    logic [4:0]            w_code;
    logic [1:0]            w_cls, w_ci;
    logic                  w_hit, w_is_init1, w_is_init2, w_is_upd, w_do_upd, w_viol;
    logic [HDR_WIDTH-1:0]  w_hdr, w_dh;
    logic [DATA_WIDTH-1:0] w_data, w_dd;
    logic                  w_unused;

    assign w_code     = dllp_i[31:27];
    assign w_cls      = w_code[2:1];
    assign w_ci       = (w_cls == 2'd3) ? 2'd0 : w_cls;
    assign w_hit      = dllp_valid_i && (dllp_i[26:24] == VC_ID[2:0]) && !w_code[0] && (w_cls != 2'd3);
    assign w_is_init1 = w_hit && (w_code[4:3] == 2'b01);
    assign w_is_init2 = w_hit && (w_code[4:3] == 2'b11);
    assign w_is_upd   = w_hit && (w_code[4:3] == 2'b10);
    assign w_hdr      = dllp_i[14 +: HDR_WIDTH];
    assign w_data     = dllp_i[DATA_WIDTH-1:0];
    assign w_dh       = w_hdr - r_lim_h[w_ci];
    assign w_dd       = w_data - r_lim_d[w_ci];
    assign w_unused   = ^{dllp_i[23:22], dllp_i[13:12]};

`ifdef TL_FC_LIMIT_CHECK_EN
    assign w_viol = (!r_inf_h[w_ci] && (w_dh > {1'b1, {(HDR_WIDTH-1){1'b0}}})) ||
                    (!r_inf_d[w_ci] && (w_dd > {1'b1, {(DATA_WIDTH-1){1'b0}}}));
`else
    assign w_viol = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FC_INIT1;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lim_h_nxt = r_lim_h;
        w_lim_d_nxt = r_lim_d;
        w_seen_nxt  = r_seen;
        w_inf_h_nxt = r_inf_h;
        w_inf_d_nxt = r_inf_d;
        w_valid_nxt = 1'b0;
        w_err_nxt   = r_err;
        w_do_upd    = 1'b0;
        w_inc_h     = '{default: '0};
        w_inc_d     = '{default: '0};
        case (r_state)
            FC_INIT1: begin
                if (w_is_init1) begin
                    w_lim_h_nxt[w_ci] = w_hdr;
                    w_lim_d_nxt[w_ci] = w_data;
                    w_seen_nxt[w_ci]  = 1'b1;
                    if (&w_seen_nxt) begin
                        w_state_nxt = FC_INIT2;
                        w_valid_nxt = 1'b1;
                        for (int unsigned i = 0; i < 3; i++) begin
                            w_inf_h_nxt[i] = (w_lim_h_nxt[i] == '0);
                            w_inf_d_nxt[i] = (w_lim_d_nxt[i] == '0);
                            w_inc_h[i]     = w_inf_h_nxt[i] ? '0 : w_lim_h_nxt[i];
                            w_inc_d[i]     = w_inf_d_nxt[i] ? '0 : w_lim_d_nxt[i];
                        end
                    end
                end
            end
            FC_INIT2: begin
                if (w_is_init2 || w_is_upd) w_state_nxt = FC_ACTIVE;
                w_do_upd = w_is_upd;
            end
            FC_ACTIVE: w_do_upd = w_is_upd;
            default:   w_state_nxt = FC_INIT1;
        endcase

        if (w_do_upd) begin
            if (w_viol) begin
                w_err_nxt = 1'b1;
            end else begin
                if (!r_inf_h[w_ci]) begin
                    w_inc_h[w_ci]     = w_dh;
                    w_lim_h_nxt[w_ci] = w_hdr;
                end
                if (!r_inf_d[w_ci]) begin
                    w_inc_d[w_ci]     = w_dd;
                    w_lim_d_nxt[w_ci] = w_data;
                end
                w_valid_nxt = (w_inc_h[w_ci] != '0) || (w_inc_d[w_ci] != '0);
            end
        end

        // Link down wins over any DLLP in the same cycle; the error flag survives.
        if (!dl_up_i) begin
            w_state_nxt = FC_INIT1;
            w_lim_h_nxt = '{default: '0};
            w_lim_d_nxt = '{default: '0};
            w_seen_nxt  = '0;
            w_inf_h_nxt = '0;
            w_inf_d_nxt = '0;
            w_valid_nxt = 1'b0;
            w_inc_h     = '{default: '0};
            w_inc_d     = '{default: '0};
        end

        w_upd_nxt.ph   = PH_W'(w_inc_h[0]);
        w_upd_nxt.pd   = PD_W'(w_inc_d[0]);
        w_upd_nxt.nph  = PH_W'(w_inc_h[1]);
        w_upd_nxt.npd  = PD_W'(w_inc_d[1]);
        w_upd_nxt.cplh = PH_W'(w_inc_h[2]);
        w_upd_nxt.cpld = PD_W'(w_inc_d[2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lim_h <= '{default: '0};
            r_lim_d <= '{default: '0};
            r_seen  <= '0;
            r_inf_h <= '0;
            r_inf_d <= '0;
            r_valid <= 1'b0;
            r_upd   <= '0;
        end else begin
            r_lim_h <= w_lim_h_nxt;
            r_lim_d <= w_lim_d_nxt;
            r_seen  <= w_seen_nxt;
            r_inf_h <= w_inf_h_nxt;
            r_inf_d <= w_inf_d_nxt;
            r_valid <= w_valid_nxt;
            r_upd   <= w_upd_nxt;
        end
    end

`ifdef TL_FC_LIMIT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= w_err_nxt;
    end
`else
    assign r_err = 1'b0;
`endif

    assign fc_update_o     = r_upd;
    assign fc_valid_o      = r_valid;
    assign fc_infinite_o   = {r_inf_h[0], r_inf_d[0], r_inf_h[1], r_inf_d[1], r_inf_h[2], r_inf_d[2]};
    assign fc_init1_done_o = (r_state != FC_INIT1);
    assign fc_init_done_o  = (r_state == FC_ACTIVE);
    assign fc_err_o        = r_err;
endmodule

// File: tb/tb_tl_fc_dllp_rx.sv
// Bench for tl_fc_dllp_rx: directed scenarios then random DLLP traffic against a credit-arithmetic model.
module tb_tl_fc_dllp_rx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, dl_up_i, dllp_valid_i;
    logic [31:0]        dllp_i;
    tl_pkg::tl_credit_t fc_update_o;
    logic               fc_valid_o;
    logic [5:0]         fc_infinite_o;
    logic               fc_init1_done_o, fc_init_done_o, fc_err_o;

    tl_fc_dllp_rx #(.HDR_WIDTH(8), .DATA_WIDTH(12), .VC_ID(0)) dut (
        .clk(clk), .rst_n(rst_n), .dl_up_i(dl_up_i), .dllp_valid_i(dllp_valid_i),
        .dllp_i(dllp_i), .fc_update_o(fc_update_o), .fc_valid_o(fc_valid_o),
        .fc_infinite_o(fc_infinite_o), .fc_init1_done_o(fc_init1_done_o),
        .fc_init_done_o(fc_init_done_o), .fc_err_o(fc_err_o)
    );

    localparam logic [4:0] I1P = 5'b01000, I1NP = 5'b01010, I1C = 5'b01100;
    localparam logic [4:0] I2P = 5'b11000, I2NP = 5'b11010, I2C = 5'b11100;
    localparam logic [4:0] UP  = 5'b10000, UNP  = 5'b10010, UC  = 5'b10100;

    int checks = 0;
    int errors = 0;

    // Model: phase 0/1/2 = INIT1/INIT2/ACTIVE; per-class limits; expected fields ph,pd,nph,npd,cplh,cpld.
    int m_phase;
    int m_lh[3], m_ld[3];
    bit m_seen[3], m_ih[3], m_id[3];
    bit m_err, e_valid;
    int e_f[6];

    function automatic logic [31:0] mk(input logic [4:0] code, input logic [2:0] vc,
                                       input logic [7:0] h, input logic [11:0] d);
        return {code, vc, 2'b00, h, 2'b00, d};
    endfunction

    task automatic model_clear_link();
        m_phase = 0;
        for (int c = 0; c < 3; c++) begin
            m_lh[c] = 0; m_ld[c] = 0; m_seen[c] = 0; m_ih[c] = 0; m_id[c] = 0;
        end
        e_valid = 0;
        e_f = '{default: 0};
    endtask

    task automatic model_update(input int c, input int h, input int d);
        int dh, dd;
        dh = (h - m_lh[c] + 256) % 256;
        dd = (d - m_ld[c] + 4096) % 4096;
`ifdef TL_FC_LIMIT_CHECK_EN
        if ((!m_ih[c] && dh > 128) || (!m_id[c] && dd > 2048)) begin
            m_err = 1;
            return;
        end
`endif
        if (!m_ih[c]) begin e_f[2*c] = dh; m_lh[c] = h; end
        if (!m_id[c]) begin e_f[2*c+1] = dd; m_ld[c] = d; end
        e_valid = (e_f[2*c] != 0) || (e_f[2*c+1] != 0);
    endtask

    task automatic model_apply(input logic v, input logic [31:0] d, input logic up);
        int kind, c, h, dv;
        e_valid = 0;
        e_f = '{default: 0};
        if (!up) begin model_clear_link(); return; end
        if (!v || d[26:24] != 3'd0) return;
        case (d[31:27])
            I1P:  begin kind = 1; c = 0; end
            I1NP: begin kind = 1; c = 1; end
            I1C:  begin kind = 1; c = 2; end
            I2P:  begin kind = 2; c = 0; end
            I2NP: begin kind = 2; c = 1; end
            I2C:  begin kind = 2; c = 2; end
            UP:   begin kind = 3; c = 0; end
            UNP:  begin kind = 3; c = 1; end
            UC:   begin kind = 3; c = 2; end
            default: return;
        endcase
        h  = int'(d[21:14]);
        dv = int'(d[11:0]);
        if (m_phase == 0) begin
            if (kind == 1) begin
                m_lh[c] = h; m_ld[c] = dv; m_seen[c] = 1;
                if (m_seen[0] && m_seen[1] && m_seen[2]) begin
                    m_phase = 1;
                    e_valid = 1;
                    for (int k = 0; k < 3; k++) begin
                        m_ih[k] = (m_lh[k] == 0);
                        m_id[k] = (m_ld[k] == 0);
                        e_f[2*k]   = m_ih[k] ? 0 : m_lh[k];
                        e_f[2*k+1] = m_id[k] ? 0 : m_ld[k];
                    end
                end
            end
        end else if (kind == 2 || kind == 3) begin
            if (m_phase == 1) m_phase = 2;
            if (kind == 3) model_update(c, h, dv);
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [59:0] eu;
        eu = {8'(e_f[0]), 12'(e_f[1]), 8'(e_f[2]), 12'(e_f[3]), 8'(e_f[4]), 12'(e_f[5])};
        check({tag, ".valid"}, 64'(fc_valid_o), 64'(e_valid));
        check({tag, ".update"}, 64'(fc_update_o), 64'(eu));
        check({tag, ".inf"}, 64'(fc_infinite_o),
              64'({m_ih[0], m_id[0], m_ih[1], m_id[1], m_ih[2], m_id[2]}));
        check({tag, ".init1"}, 64'(fc_init1_done_o), 64'(m_phase >= 1));
        check({tag, ".init"}, 64'(fc_init_done_o), 64'(m_phase == 2));
        check({tag, ".err"}, 64'(fc_err_o), 64'(m_err));
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] d, input logic up);
        dllp_valid_i = v;
        dllp_i       = d;
        dl_up_i      = up;
        @(posedge clk);
        #1;
        model_apply(v, d, up);
        dllp_valid_i = 1'b0;
        dl_up_i      = 1'b1;
        check_all(tag);
    endtask

    task automatic finite_init(input string tag);
        step({tag, ".i1p"},  1'b1, mk(I1P, 3'd0, 8'd32, 12'd256), 1'b1);
        step({tag, ".i1np"}, 1'b1, mk(I1NP, 3'd0, 8'd16, 12'd8), 1'b1);
        step({tag, ".i1c"},  1'b1, mk(I1C, 3'd0, 8'd64, 12'd1024), 1'b1);
        check({tag, ".pulse"}, 64'(fc_update_o),
              64'({8'd32, 12'd256, 8'd16, 12'd8, 8'd64, 12'd1024}));
        check({tag, ".pulse_v"}, 64'(fc_valid_o), 64'(1'b1));
        check({tag, ".init1_done"}, 64'(fc_init1_done_o), 64'(1'b1));
    endtask

    logic [4:0]  r_codes [10];
    logic [31:0] r_d;
    logic        r_v, r_up;

    initial begin
        rst_n = 1'b0; dl_up_i = 1'b1; dllp_valid_i = 1'b0; dllp_i = '0;
        m_err = 0;
        model_clear_link();
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset");

        step("drop_with_linkdown", 1'b1, mk(I1P, 3'd0, 8'd99, 12'd99), 1'b0);
        finite_init("finite");
        step("i1_in_init2", 1'b1, mk(I1P, 3'd0, 8'd1, 12'd1), 1'b1);
        step("i2p", 1'b1, mk(I2P, 3'd0, 8'd0, 12'd0), 1'b1);
        check("init_done", 64'(fc_init_done_o), 64'(1'b1));

        step("upd_to250", 1'b1, mk(UP, 3'd0, 8'd250, 12'd500), 1'b1);
        step("wrap", 1'b1, mk(UP, 3'd0, 8'd4, 12'd600), 1'b1);
        check("wrap_fields", 64'(fc_update_o), 64'({8'd10, 12'd100, 8'd0, 12'd0, 8'd0, 12'd0}));
        step("zero_delta", 1'b1, mk(UP, 3'd0, 8'd4, 12'd600), 1'b1);
        check("zero_delta_nopulse", 64'(fc_valid_o), 64'(1'b0));
        step("ack", 1'b1, 32'h0000_0000, 1'b1);
        step("vc1", 1'b1, mk(UP, 3'd1, 8'd7, 12'd600), 1'b1);
        step("i1_in_active", 1'b1, mk(I1NP, 3'd0, 8'd1, 12'd1), 1'b1);
        step("pd_2600", 1'b1, mk(UP, 3'd0, 8'd4, 12'd2600), 1'b1);
        step("pd_0", 1'b1, mk(UP, 3'd0, 8'd4, 12'd0), 1'b1);
        step("pd_3000", 1'b1, mk(UP, 3'd0, 8'd4, 12'd3000), 1'b1);
`ifdef TL_FC_LIMIT_CHECK_EN
        check("limit_err", 64'(fc_err_o), 64'(1'b1));
        check("limit_nopulse", 64'(fc_valid_o), 64'(1'b0));
`else
        check("nolimit_pd", 64'(fc_update_o), 64'({8'd0, 12'd3000, 8'd0, 12'd0, 8'd0, 12'd0}));
`endif

        step("linkdown", 1'b0, 32'h0, 1'b0);
        check("linkdown_init1", 64'(fc_init1_done_o), 64'(1'b0));

        step("inf.i1p",  1'b1, mk(I1P, 3'd0, 8'd32, 12'd256), 1'b1);
        step("inf.i1np", 1'b1, mk(I1NP, 3'd0, 8'd16, 12'd8), 1'b1);
        step("inf.i1c",  1'b1, mk(I1C, 3'd0, 8'd0, 12'd0), 1'b1);
        check("inf_flags", 64'(fc_infinite_o), 64'(6'b000011));
        check("inf_pulse", 64'(fc_update_o), 64'({8'd32, 12'd256, 8'd16, 12'd8, 8'd0, 12'd0}));
        step("inf.i2np", 1'b1, mk(I2NP, 3'd0, 8'd0, 12'd0), 1'b1);
        step("inf.updc", 1'b1, mk(UC, 3'd0, 8'd5, 12'd0), 1'b1);
        check("inf_nopulse", 64'(fc_valid_o), 64'(1'b0));

        step("linkdown2", 1'b0, 32'h0, 1'b0);
        finite_init("refinite");

        r_codes = '{I1P, I1NP, I1C, I2P, I2NP, I2C, UP, UNP, UC, 5'b00000};
        for (int n = 0; n < 1500; n++) begin
            r_v  = ($urandom_range(0, 3) != 0);
            r_up = ($urandom_range(0, 99) != 0);
            r_d  = mk(r_codes[$urandom_range(0, 9)],
                      ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0,
                      ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom));
            if ($urandom_range(0, 7) == 0) r_d[31:24] = 8'($urandom);
            step("rand", r_v, r_d, r_up);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #2;
                m_err = 0;
                model_clear_link();
                check_all("midreset");
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
